// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared TileLink-UL definitions for the 32-bit system bus slice.
//   - bus geometry (beat width, largest transfer, client source width)
//   - A/D channel opcode constants
//   - has_data / num_beats helpers used to size A-channel bursts
// No ports; imported by the arbiter and its lock/round-robin sub-module.
// ---------------------------------------------------------------------------
package tl_pkg;

    localparam int BEAT_BYTES  = 4;
    localparam int BEAT_LG     = $clog2(BEAT_BYTES);
    localparam int MAX_SIZE_LG = 6;
    localparam int SRC_W       = 2;

    // beats_left only ever holds (beats - 1), so 4 bits covers a 16-beat burst;
    // a beat count itself needs one more bit to represent 16.
    localparam int BEAT_CNT_W  = MAX_SIZE_LG - BEAT_LG;
    localparam int BEATS_W     = BEAT_CNT_W + 1;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // Puts and atomics carry data on A; Get/Hint (opcode[2] set) do not.
    function automatic logic has_data(input logic [2:0] opcode);
        return ~opcode[2];
    endfunction

    // Number of A beats in a message. Sizes above MAX_SIZE_LG are illegal on
    // this bus and are not guarded against.
    function automatic logic [BEATS_W-1:0] num_beats(input logic [2:0] opcode,
                                                     input logic [2:0] size);
        logic [7:0] bytes;
        logic [7:0] beats;
        bytes = 8'd1 << size;
        beats = bytes >> BEAT_LG;
        if (!has_data(opcode) || beats == 8'd0) begin
            return BEATS_W'(1);
        end
        return beats[BEATS_W-1:0];
    endfunction

endpackage

// File: rtl/tl_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tl_rr_lock_arbiter
// Two-way round-robin arbiter that holds its grant for the length of a
// multi-beat message.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   valid[1:0]     request from each client
//   beats          beat count of the currently granted client's message
//   fire           the granted beat was accepted downstream this cycle
//   grant          index of the client currently granted
//   grant_valid    a grant exists (locked, or at least one request)
// ---------------------------------------------------------------------------
module tl_rr_lock_arbiter
    import tl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         valid,
    input  logic [BEATS_W-1:0] beats,
    input  logic               fire,
    output logic               grant,
    output logic               grant_valid
);

    logic                  locked;
    logic                  owner;
    logic                  last_grant;
    logic [BEAT_CNT_W-1:0] beats_left;
    logic [BEATS_W-1:0]    beats_minus_one;

    assign beats_minus_one = beats - BEATS_W'(1);

    // Grant selection: a locked burst keeps its owner even when the owner
    // drops valid; otherwise a lone requester wins and contention alternates.
    // With no requests the grant value is irrelevant since grant_valid is low.
    always_comb begin
        grant       = ~last_grant;
        grant_valid = locked | valid[0] | valid[1];
        if (locked) begin
            grant = owner;
        end else if (valid[0] && !valid[1]) begin
            grant = 1'b0;
        end else if (valid[1] && !valid[0]) begin
            grant = 1'b1;
        end
    end

    // Control state: round-robin pointer moves only on a message's first
    // beat; the lock counts down only on accepted beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            locked     <= 1'b0;
            owner      <= 1'b0;
            beats_left <= '0;
            last_grant <= 1'b1;
        end else if (fire) begin
            if (locked) begin
                beats_left <= beats_left - BEAT_CNT_W'(1);
                if (beats_left == BEAT_CNT_W'(1)) begin
                    locked <= 1'b0;
                end
            end else begin
                last_grant <= grant;
                if (beats > BEATS_W'(1)) begin
                    locked     <= 1'b1;
                    owner      <= grant;
                    beats_left <= beats_minus_one[BEAT_CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/tl_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tl_arbiter_2to1
// Two-client TileLink-UL arbiter sharing one manager-side port.
//   A channel: round-robin between in0/in1, burst-locked; the manager-side
//              source gains a top bit naming the client.
//   D channel: routed back to the client named by the source top bit.
// Purely combinational data path; only arbitration state is registered.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   auto_in0_* / auto_in1_* client ports (A in, D out)
//   auto_out_*              manager port (A out, D in), source is SRC_W+1
// ---------------------------------------------------------------------------
module tl_arbiter_2to1
    import tl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,

    output logic             auto_in0_a_ready,
    input  logic             auto_in0_a_valid,
    input  logic [2:0]       auto_in0_a_bits_opcode,
    input  logic [2:0]       auto_in0_a_bits_param,
    input  logic [2:0]       auto_in0_a_bits_size,
    input  logic [SRC_W-1:0] auto_in0_a_bits_source,
    input  logic [31:0]      auto_in0_a_bits_address,
    input  logic [3:0]       auto_in0_a_bits_mask,
    input  logic [31:0]      auto_in0_a_bits_data,
    input  logic             auto_in0_a_bits_corrupt,
    input  logic             auto_in0_d_ready,
    output logic             auto_in0_d_valid,
    output logic [2:0]       auto_in0_d_bits_opcode,
    output logic [2:0]       auto_in0_d_bits_size,
    output logic [SRC_W-1:0] auto_in0_d_bits_source,
    output logic             auto_in0_d_bits_denied,
    output logic [31:0]      auto_in0_d_bits_data,
    output logic             auto_in0_d_bits_corrupt,

    output logic             auto_in1_a_ready,
    input  logic             auto_in1_a_valid,
    input  logic [2:0]       auto_in1_a_bits_opcode,
    input  logic [2:0]       auto_in1_a_bits_param,
    input  logic [2:0]       auto_in1_a_bits_size,
    input  logic [SRC_W-1:0] auto_in1_a_bits_source,
    input  logic [31:0]      auto_in1_a_bits_address,
    input  logic [3:0]       auto_in1_a_bits_mask,
    input  logic [31:0]      auto_in1_a_bits_data,
    input  logic             auto_in1_a_bits_corrupt,
    input  logic             auto_in1_d_ready,
    output logic             auto_in1_d_valid,
    output logic [2:0]       auto_in1_d_bits_opcode,
    output logic [2:0]       auto_in1_d_bits_size,
    output logic [SRC_W-1:0] auto_in1_d_bits_source,
    output logic             auto_in1_d_bits_denied,
    output logic [31:0]      auto_in1_d_bits_data,
    output logic             auto_in1_d_bits_corrupt,

    input  logic             auto_out_a_ready,
    output logic             auto_out_a_valid,
    output logic [2:0]       auto_out_a_bits_opcode,
    output logic [2:0]       auto_out_a_bits_param,
    output logic [2:0]       auto_out_a_bits_size,
    output logic [SRC_W:0]   auto_out_a_bits_source,
    output logic [31:0]      auto_out_a_bits_address,
    output logic [3:0]       auto_out_a_bits_mask,
    output logic [31:0]      auto_out_a_bits_data,
    output logic             auto_out_a_bits_corrupt,
    output logic             auto_out_d_ready,
    input  logic             auto_out_d_valid,
    input  logic [2:0]       auto_out_d_bits_opcode,
    input  logic [2:0]       auto_out_d_bits_size,
    input  logic [SRC_W:0]   auto_out_d_bits_source,
    input  logic             auto_out_d_bits_denied,
    input  logic [31:0]      auto_out_d_bits_data,
    input  logic             auto_out_d_bits_corrupt
);

    logic [1:0]         in_valid;
    logic [BEATS_W-1:0] grant_beats;
    logic               grant;
    logic               grant_valid;
    logic               a_fire;
    logic               d_sel;

    assign in_valid = {auto_in1_a_valid, auto_in0_a_valid};

    // Only the granted client's message length matters to the lock logic.
    assign grant_beats = grant
        ? num_beats(auto_in1_a_bits_opcode, auto_in1_a_bits_size)
        : num_beats(auto_in0_a_bits_opcode, auto_in0_a_bits_size);

    assign a_fire = auto_out_a_valid & auto_out_a_ready;

    tl_rr_lock_arbiter u_arb (
        .clock       (clock),
        .reset       (reset),
        .valid       (in_valid),
        .beats       (grant_beats),
        .fire        (a_fire),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // A channel: forward the grantee's beat, tagging the source with the
    // client index. Handshakes are held off while reset is high.
    always_comb begin
        auto_out_a_valid        = ~reset & in_valid[grant];
        auto_in0_a_ready        = ~reset & grant_valid & ~grant & auto_out_a_ready;
        auto_in1_a_ready        = ~reset & grant_valid &  grant & auto_out_a_ready;
        auto_out_a_bits_opcode  = auto_in0_a_bits_opcode;
        auto_out_a_bits_param   = auto_in0_a_bits_param;
        auto_out_a_bits_size    = auto_in0_a_bits_size;
        auto_out_a_bits_source  = {1'b0, auto_in0_a_bits_source};
        auto_out_a_bits_address = auto_in0_a_bits_address;
        auto_out_a_bits_mask    = auto_in0_a_bits_mask;
        auto_out_a_bits_data    = auto_in0_a_bits_data;
        auto_out_a_bits_corrupt = auto_in0_a_bits_corrupt;
        if (grant) begin
            auto_out_a_bits_opcode  = auto_in1_a_bits_opcode;
            auto_out_a_bits_param   = auto_in1_a_bits_param;
            auto_out_a_bits_size    = auto_in1_a_bits_size;
            auto_out_a_bits_source  = {1'b1, auto_in1_a_bits_source};
            auto_out_a_bits_address = auto_in1_a_bits_address;
            auto_out_a_bits_mask    = auto_in1_a_bits_mask;
            auto_out_a_bits_data    = auto_in1_a_bits_data;
            auto_out_a_bits_corrupt = auto_in1_a_bits_corrupt;
        end
    end

    // D channel: the source top bit names the client; payload is broadcast
    // and only the addressed client sees valid.
    assign d_sel = auto_out_d_bits_source[SRC_W];

    always_comb begin
        auto_in0_d_valid = ~reset & auto_out_d_valid & ~d_sel;
        auto_in1_d_valid = ~reset & auto_out_d_valid &  d_sel;
        auto_out_d_ready = ~reset & (d_sel ? auto_in1_d_ready : auto_in0_d_ready);
    end

    assign auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in0_d_bits_size    = auto_out_d_bits_size;
    assign auto_in0_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in0_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in0_d_bits_data    = auto_out_d_bits_data;
    assign auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;

    assign auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in1_d_bits_size    = auto_out_d_bits_size;
    assign auto_in1_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in1_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in1_d_bits_data    = auto_out_d_bits_data;
    assign auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tb_tl_arbiter_2to1
// Directed scenarios for the 2:1 TileLink-UL arbiter followed by a random
// run checked against a message-level reference model.
// ---------------------------------------------------------------------------
module tb_tl_arbiter_2to1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in0_a_ready, in1_a_ready;
    logic        in0_a_valid, in1_a_valid;
    logic [2:0]  in0_op, in1_op, in0_size, in1_size;
    logic [1:0]  in0_src, in1_src;
    logic [31:0] in0_addr, in1_addr, in0_data, in1_data;
    logic        in0_d_ready, in1_d_ready;
    logic        in0_d_valid, in1_d_valid;
    logic [2:0]  in0_d_op, in1_d_op, in0_d_size, in1_d_size;
    logic [1:0]  in0_d_src, in1_d_src;
    logic        in0_d_denied, in1_d_denied, in0_d_corrupt, in1_d_corrupt;
    logic [31:0] in0_d_data, in1_d_data;

    logic        out_a_ready;
    logic        out_a_valid;
    logic [2:0]  out_a_op, out_a_param, out_a_size;
    logic [2:0]  out_a_src;
    logic [31:0] out_a_addr, out_a_data;
    logic [3:0]  out_a_mask;
    logic        out_a_corrupt;
    logic        out_d_ready;
    logic        out_d_valid;
    logic [2:0]  out_d_op, out_d_size, out_d_src;
    logic [31:0] out_d_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    tl_arbiter_2to1 dut (
        .clock                   (clock),
        .reset                   (reset),
        .auto_in0_a_ready        (in0_a_ready),
        .auto_in0_a_valid        (in0_a_valid),
        .auto_in0_a_bits_opcode  (in0_op),
        .auto_in0_a_bits_param   (3'd0),
        .auto_in0_a_bits_size    (in0_size),
        .auto_in0_a_bits_source  (in0_src),
        .auto_in0_a_bits_address (in0_addr),
        .auto_in0_a_bits_mask    (4'hF),
        .auto_in0_a_bits_data    (in0_data),
        .auto_in0_a_bits_corrupt (1'b0),
        .auto_in0_d_ready        (in0_d_ready),
        .auto_in0_d_valid        (in0_d_valid),
        .auto_in0_d_bits_opcode  (in0_d_op),
        .auto_in0_d_bits_size    (in0_d_size),
        .auto_in0_d_bits_source  (in0_d_src),
        .auto_in0_d_bits_denied  (in0_d_denied),
        .auto_in0_d_bits_data    (in0_d_data),
        .auto_in0_d_bits_corrupt (in0_d_corrupt),
        .auto_in1_a_ready        (in1_a_ready),
        .auto_in1_a_valid        (in1_a_valid),
        .auto_in1_a_bits_opcode  (in1_op),
        .auto_in1_a_bits_param   (3'd0),
        .auto_in1_a_bits_size    (in1_size),
        .auto_in1_a_bits_source  (in1_src),
        .auto_in1_a_bits_address (in1_addr),
        .auto_in1_a_bits_mask    (4'hF),
        .auto_in1_a_bits_data    (in1_data),
        .auto_in1_a_bits_corrupt (1'b0),
        .auto_in1_d_ready        (in1_d_ready),
        .auto_in1_d_valid        (in1_d_valid),
        .auto_in1_d_bits_opcode  (in1_d_op),
        .auto_in1_d_bits_size    (in1_d_size),
        .auto_in1_d_bits_source  (in1_d_src),
        .auto_in1_d_bits_denied  (in1_d_denied),
        .auto_in1_d_bits_data    (in1_d_data),
        .auto_in1_d_bits_corrupt (in1_d_corrupt),
        .auto_out_a_ready        (out_a_ready),
        .auto_out_a_valid        (out_a_valid),
        .auto_out_a_bits_opcode  (out_a_op),
        .auto_out_a_bits_param   (out_a_param),
        .auto_out_a_bits_size    (out_a_size),
        .auto_out_a_bits_source  (out_a_src),
        .auto_out_a_bits_address (out_a_addr),
        .auto_out_a_bits_mask    (out_a_mask),
        .auto_out_a_bits_data    (out_a_data),
        .auto_out_a_bits_corrupt (out_a_corrupt),
        .auto_out_d_ready        (out_d_ready),
        .auto_out_d_valid        (out_d_valid),
        .auto_out_d_bits_opcode  (out_d_op),
        .auto_out_d_bits_size    (out_d_size),
        .auto_out_d_bits_source  (out_d_src),
        .auto_out_d_bits_denied  (1'b0),
        .auto_out_d_bits_data    (out_d_data),
        .auto_out_d_bits_corrupt (1'b0)
    );

    // Stimulus helpers (no checking here)
    task automatic drive_in0(input logic v, input logic [2:0] op, input logic [2:0] sz,
                             input logic [1:0] src, input logic [31:0] addr, input logic [31:0] data);
        in0_a_valid = v; in0_op = op; in0_size = sz; in0_src = src; in0_addr = addr; in0_data = data;
    endtask

    task automatic drive_in1(input logic v, input logic [2:0] op, input logic [2:0] sz,
                             input logic [1:0] src, input logic [31:0] addr, input logic [31:0] data);
        in1_a_valid = v; in1_op = op; in1_size = sz; in1_src = src; in1_addr = addr; in1_data = data;
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Beats in an A message, from the TileLink rules rather than the RTL
    function automatic int model_beats(input logic [2:0] op, input logic [2:0] sz);
        int n;
        if (op >= 3'd4) return 1;
        n = (1 << sz) / 4;
        return (n < 1) ? 1 : n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive_in0(1, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        drive_in1(1, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        out_a_ready = 1; out_d_valid = 1; out_d_src = 3'b100;
        in0_d_ready = 1; in1_d_ready = 1;
        @(negedge clock);
        n_compared += 5;
        if (out_a_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_a_valid got %b want 0", out_a_valid); end
        if (in0_a_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_in0_a_ready got %b want 0", in0_a_ready); end
        if (in1_a_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_in1_a_ready got %b want 0", in1_a_ready); end
        if (in1_d_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_in1_d_valid got %b want 0", in1_d_valid); end
        if (out_d_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_d_ready got %b want 0", out_d_ready); end
        advance();
        reset = 1'b0;
        drive_in0(0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        drive_in1(0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        out_d_valid = 0;
    endtask

    task automatic test_single_get();
        drive_in0(1, 3'd4, 3'd2, 2'd1, 32'h0000_0100, 32'h0);
        out_a_ready = 1;
        @(negedge clock);
        n_compared += 4;
        if (out_a_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL get_valid got %b want 1", out_a_valid); end
        if (out_a_src !== 3'b001) begin n_mismatched++; $display("[TB] FAIL get_source got %b want 001", out_a_src); end
        if (in0_a_ready !== 1'b1 || in1_a_ready !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL get_readies got %b%b want 01", in1_a_ready, in0_a_ready);
        end
        if (out_a_addr !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL get_address got %h want 00000100", out_a_addr); end
        advance();
        in0_a_valid = 0;
    endtask

    // After the single in0 Get, contention starts with in1; five rounds
    // leave in1 as the most recent winner.
    task automatic test_alternating();
        logic g;
        drive_in0(1, 3'd4, 3'd2, 2'd2, 32'h10, 32'h0);
        drive_in1(1, 3'd4, 3'd2, 2'd1, 32'h20, 32'h0);
        out_a_ready = 1;
        for (int k = 0; k < 5; k++) begin
            g = (k % 2 == 0);
            @(negedge clock);
            n_compared += 2;
            if (out_a_src !== {g, (g ? 2'd1 : 2'd2)}) begin
                n_mismatched++; $display("[TB] FAIL alt_source[%0d] got %b want %b", k, out_a_src, {g, (g ? 2'd1 : 2'd2)});
            end
            if (in0_a_ready !== !g || in1_a_ready !== g) begin
                n_mismatched++; $display("[TB] FAIL alt_ready[%0d] got %b%b want %b%b", k, in1_a_ready, in0_a_ready, g, !g);
            end
            advance();
        end
    endtask

    task automatic test_burst_hold();
        drive_in1(1, 3'd4, 3'd2, 2'd3, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive_in0(1, 3'd0, 3'd4, 2'd0, 32'h30, 32'hA000_0000 + k);
            @(negedge clock);
            n_compared += 3;
            if (out_a_src !== 3'b000) begin n_mismatched++; $display("[TB] FAIL hold_source[%0d] got %b want 000", k, out_a_src); end
            if (in1_a_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_in1_ready[%0d] got %b want 0", k, in1_a_ready); end
            if (out_a_data !== 32'hA000_0000 + k) begin
                n_mismatched++; $display("[TB] FAIL hold_data[%0d] got %h want %h", k, out_a_data, 32'hA000_0000 + k);
            end
            advance();
        end
        @(negedge clock);
        n_compared += 2;
        if (in1_a_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_release_ready got %b want 1", in1_a_ready); end
        if (out_a_src !== 3'b111) begin n_mismatched++; $display("[TB] FAIL hold_release_source got %b want 111", out_a_src); end
        advance();
        in0_a_valid = 0; in1_a_valid = 0;
    endtask

    task automatic test_burst_stall();
        logic v0_tab  [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic rdy_tab [9] = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
        drive_in1(1, 3'd4, 3'd2, 2'd2, 32'h50, 32'h0);
        for (int k = 0; k < 8; k++) begin
            drive_in0(v0_tab[k], 3'd0, 3'd4, 2'd1, 32'h60, 32'h0);
            out_a_ready = rdy_tab[k];
            @(negedge clock);
            n_compared += 2;
            if (out_a_valid !== v0_tab[k]) begin
                n_mismatched++; $display("[TB] FAIL stall_valid[%0d] got %b want %b", k, out_a_valid, v0_tab[k]);
            end
            if (in1_a_ready !== 1'b0 || (v0_tab[k] && out_a_src !== 3'b001)) begin
                n_mismatched++; $display("[TB] FAIL stall_owner[%0d] got ready1=%b src=%b want ready1=0 src=001", k, in1_a_ready, out_a_src);
            end
            advance();
        end
        out_a_ready = rdy_tab[8];
        @(negedge clock);
        n_compared++;
        if (in1_a_ready !== 1'b1 || out_a_src !== 3'b110) begin
            n_mismatched++; $display("[TB] FAIL stall_release got ready1=%b src=%b want 1 110", in1_a_ready, out_a_src);
        end
        advance();
        in0_a_valid = 0; in1_a_valid = 0;
    endtask

    task automatic test_d_route();
        logic [2:0]  src_tab  [4] = '{3'b110, 3'b110, 3'b110, 3'b010};
        logic        rdy1_tab [4] = '{0, 1, 1, 0};
        logic [31:0] dat_tab  [4] = '{32'hD0, 32'hD0, 32'hD1, 32'hD2};
        logic        sel;
        out_d_op = 3'd1; out_d_size = 3'd3; out_d_valid = 1; in0_d_ready = 1;
        for (int k = 0; k < 4; k++) begin
            out_d_src = src_tab[k]; in1_d_ready = rdy1_tab[k]; out_d_data = dat_tab[k];
            sel = src_tab[k][2];
            @(negedge clock);
            n_compared += 4;
            if (in1_d_valid !== sel || in0_d_valid !== !sel) begin
                n_mismatched++; $display("[TB] FAIL d_valids[%0d] got %b%b want %b%b", k, in1_d_valid, in0_d_valid, sel, !sel);
            end
            if ((sel ? in1_d_src : in0_d_src) !== src_tab[k][1:0]) begin
                n_mismatched++; $display("[TB] FAIL d_source[%0d] got %b want %b", k, (sel ? in1_d_src : in0_d_src), src_tab[k][1:0]);
            end
            if (out_d_ready !== (sel ? rdy1_tab[k] : 1'b1)) begin
                n_mismatched++; $display("[TB] FAIL d_ready[%0d] got %b want %b", k, out_d_ready, (sel ? rdy1_tab[k] : 1'b1));
            end
            if ((sel ? in1_d_data : in0_d_data) !== dat_tab[k]) begin
                n_mismatched++; $display("[TB] FAIL d_data[%0d] got %h want %h", k, (sel ? in1_d_data : in0_d_data), dat_tab[k]);
            end
            advance();
        end
        out_d_valid = 0;
    endtask

    // Most recent contention winner is in1, so in0 takes the burst; reset on
    // beat 2 must drop the lock and restore in0 priority.
    task automatic test_reset_mid_burst();
        out_a_ready = 1;
        drive_in0(1, 3'd0, 3'd4, 2'd0, 32'h70, 32'h1);
        drive_in1(1, 3'd4, 3'd2, 2'd1, 32'h80, 32'h0);
        advance();
        reset = 1;
        @(negedge clock);
        n_compared++;
        if (out_a_valid !== 1'b0 || in0_a_ready !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL rst_burst_gate got valid=%b ready0=%b want 0 0", out_a_valid, in0_a_ready);
        end
        advance();
        reset = 0;
        in0_a_valid = 0; out_a_ready = 0;
        @(negedge clock);
        n_compared++;
        if (out_a_valid !== 1'b1 || out_a_src !== 3'b101) begin
            n_mismatched++; $display("[TB] FAIL rst_unlock got valid=%b src=%b want 1 101", out_a_valid, out_a_src);
        end
        advance();
        drive_in0(1, 3'd4, 3'd2, 2'd2, 32'h90, 32'h0);
        out_a_ready = 1;
        @(negedge clock);
        n_compared++;
        if (out_a_src !== 3'b010 || in0_a_ready !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL rst_priority got src=%b ready0=%b want 010 1", out_a_src, in0_a_ready);
        end
        advance();
        in0_a_valid = 0; in1_a_valid = 0;
    endtask

    // Random traffic against a message-level model: an in-progress message
    // (owner + beats still to send) and the client that won the last message.
    task automatic test_random(input int cycles);
        logic [2:0] op_tab [3] = '{3'd0, 3'd1, 3'd4};
        logic       m_busy, m_owner, m_last;
        int         m_left;
        logic       g, has, exp_valid, exp_r0, exp_r1, sel;
        logic [2:0] exp_src;
        logic [31:0] exp_addr, exp_data;
        reset = 1; advance(); reset = 0;
        m_busy = 0; m_owner = 0; m_left = 0; m_last = 1;
        for (int c = 0; c < cycles; c++) begin
            drive_in0(1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 2)], 3'($urandom_range(0, 4)),
                      2'($urandom), $urandom, $urandom);
            drive_in1(1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 2)], 3'($urandom_range(0, 4)),
                      2'($urandom), $urandom, $urandom);
            out_a_ready = ($urandom_range(0, 3) != 0);
            out_d_valid = 1'($urandom); out_d_src = 3'($urandom); out_d_data = $urandom;
            in0_d_ready = 1'($urandom); in1_d_ready = 1'($urandom);
            @(negedge clock);
            if (m_busy)                        g = m_owner;
            else if (in0_a_valid && in1_a_valid) g = !m_last;
            else                               g = in1_a_valid;
            has       = m_busy || in0_a_valid || in1_a_valid;
            exp_valid = g ? in1_a_valid : in0_a_valid;
            exp_r0    = has && !g && out_a_ready;
            exp_r1    = has &&  g && out_a_ready;
            exp_src   = {g, (g ? in1_src : in0_src)};
            exp_addr  = g ? in1_addr : in0_addr;
            exp_data  = g ? in1_data : in0_data;
            n_compared += 2;
            if (out_a_valid !== exp_valid) begin
                n_mismatched++; $display("[TB] FAIL rnd_a_valid[%0d] got %b want %b", c, out_a_valid, exp_valid);
            end
            if (in0_a_ready !== exp_r0 || in1_a_ready !== exp_r1) begin
                n_mismatched++; $display("[TB] FAIL rnd_a_ready[%0d] got %b%b want %b%b", c, in1_a_ready, in0_a_ready, exp_r1, exp_r0);
            end
            if (exp_valid) begin
                n_compared++;
                if (out_a_src !== exp_src || out_a_addr !== exp_addr || out_a_data !== exp_data) begin
                    n_mismatched++;
                    $display("[TB] FAIL rnd_a_bits[%0d] got src=%b addr=%h data=%h want src=%b addr=%h data=%h",
                             c, out_a_src, out_a_addr, out_a_data, exp_src, exp_addr, exp_data);
                end
            end
            sel = out_d_src[2];
            n_compared += 2;
            if (in0_d_valid !== (out_d_valid && !sel) || in1_d_valid !== (out_d_valid && sel)) begin
                n_mismatched++; $display("[TB] FAIL rnd_d_valid[%0d] got %b%b sel=%b", c, in1_d_valid, in0_d_valid, sel);
            end
            if (out_d_ready !== (sel ? in1_d_ready : in0_d_ready)) begin
                n_mismatched++; $display("[TB] FAIL rnd_d_ready[%0d] got %b want %b", c, out_d_ready, (sel ? in1_d_ready : in0_d_ready));
            end
            if (exp_valid && out_a_ready) begin
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) m_busy = 0;
                end else begin
                    m_last = g;
                    m_left = model_beats(g ? in1_op : in0_op, g ? in1_size : in0_size) - 1;
                    if (m_left > 0) begin
                        m_busy  = 1;
                        m_owner = g;
                    end
                end
            end
            advance();
        end
    endtask

    initial begin
        in0_d_ready = 0; in1_d_ready = 0; out_d_valid = 0;
        out_d_op = 0; out_d_size = 0; out_d_src = 0; out_d_data = 0;
        out_a_ready = 0;
        test_reset();
        test_single_get();
        test_alternating();
        test_burst_hold();
        test_burst_stall();
        test_d_route();
        test_reset_mid_burst();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
